// File: rtl/fir_decim_if.sv
// Sample-stream bundle for the decimating FIR stage: oversampled input strobe/data
// and the decimated output strobe/data.
interface fir_decim_if;
  logic        in_valid;
  logic [31:0] x_0;
  logic [31:0] x_1;
  logic        out_valid;
  logic [31:0] y_0;
  logic [31:0] y_1;

  modport master (output in_valid, x_0, x_1, input out_valid, y_0, y_1);
  modport slave  (input in_valid, x_0, x_1, output out_valid, y_0, y_1);
endinterface

// File: rtl/fir_decim_stage.sv
// Stereo decimating FIR: 128-deep delay lines, one time-shared MAC per channel, sync coef ROM.
// Optional FIR_DECIM_SAT_EN saturates the output scaling instead of wrapping.
module fir_decim_stage #(
  parameter int NTAPS = 120,
  parameter int ACC_W = 64
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  decim_x,
  output logic [6:0]  coef_addr,
  input  logic [31:0] coef_data,
  output logic        busy,
  output logic        overrun,
  fir_decim_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_DRAIN, ST_DONE} state_t;

  state_t                   state_r, state_s;
  logic [6:0]               tap_r, wp_r, base_r, raddr_s;
  logic [2:0]               phase_r, phase_max_s;
  logic [1:0]               decim_r;
  logic                     req_r, drain_r, rd_v_r, prod_v_r;
  logic                     trig_s, dchg_s, mac_busy_s;
  logic                     out_valid_r, busy_r, overrun_r;
  logic [31:0]              y0_r, y1_r;
  logic [31:0]              mem0 [128];
  logic [31:0]              mem1 [128];
  logic signed [27:0]       rd0_r, rd1_r;
  logic signed [59:0]       prod0_r, prod1_r;
  logic signed [ACC_W-1:0]  acc0_r, acc1_r;

  function automatic logic [31:0] scale_acc(input logic signed [ACC_W-1:0] a);
`ifdef FIR_DECIM_SAT_EN
    if (a[ACC_W-1:58] != {(ACC_W-58){a[58]}}) begin
      return a[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      return a[58:27];
    end
`else
    return a[58:27];
`endif
  endfunction

  assign raddr_s    = base_r - tap_r;
  assign mac_busy_s = (state_r == ST_MAC) || (state_r == ST_DRAIN);
  assign dchg_s     = (state_r == ST_IDLE) && (decim_x != decim_r);
  assign trig_s     = bus.in_valid && !dchg_s && (phase_r == phase_max_s);

  // Last phase index of a decimation group for the latched ratio
  always_comb begin
    phase_max_s = 3'd0;
    case (decim_r)
      2'd0:    phase_max_s = 3'd0;
      2'd1:    phase_max_s = 3'd1;
      2'd2:    phase_max_s = 3'd3;
      2'd3:    phase_max_s = 3'd7;
      default: phase_max_s = 3'd0;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  if (req_r) state_s = ST_MAC; else state_s = ST_IDLE;
      ST_MAC:   if (tap_r == 7'(NTAPS - 1)) state_s = ST_DRAIN; else state_s = ST_MAC;
      ST_DRAIN: if (drain_r) state_s = ST_DONE; else state_s = ST_DRAIN;
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Control: FSM state, write pointer, phase counter, request and status flags
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      tap_r     <= 7'd0;
      wp_r      <= 7'd0;
      base_r    <= 7'd0;
      phase_r   <= 3'd0;
      decim_r   <= 2'd0;
      req_r     <= 1'b0;
      drain_r   <= 1'b0;
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else if (!enable) begin
      state_r   <= ST_IDLE;
      tap_r     <= 7'd0;
      wp_r      <= 7'd0;
      base_r    <= 7'd0;
      phase_r   <= 3'd0;
      decim_r   <= 2'd0;
      req_r     <= 1'b0;
      drain_r   <= 1'b0;
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
      drain_r <= (state_r == ST_DRAIN) ? ~drain_r : 1'b0;
      if (state_r == ST_MAC && tap_r != 7'(NTAPS - 1)) begin
        tap_r <= tap_r + 7'd1;
      end else begin
        tap_r <= 7'd0;
      end
      if (bus.in_valid) begin
        wp_r <= wp_r + 7'd1;
      end else begin
        wp_r <= wp_r;
      end
      if (dchg_s) begin
        decim_r <= decim_x;
        phase_r <= 3'd0;
      end else if (bus.in_valid) begin
        phase_r <= trig_s ? 3'd0 : phase_r + 3'd1;
      end else begin
        phase_r <= phase_r;
      end
      // A trigger landing in MAC/DRAIN is lost; one landing in DONE starts from IDLE next cycle
      req_r <= trig_s && !mac_busy_s;
      if (trig_s && !mac_busy_s) begin
        base_r <= wp_r;
      end else begin
        base_r <= base_r;
      end
      if (trig_s && mac_busy_s) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  // Delay-line RAMs: write on every input strobe, registered read at raddr
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 128; i++) begin
        mem0[i] <= 32'd0;
        mem1[i] <= 32'd0;
      end
      rd0_r <= 28'sd0;
      rd1_r <= 28'sd0;
    end else begin
      if (enable && bus.in_valid) begin
        mem0[wp_r] <= bus.x_0;
        mem1[wp_r] <= bus.x_1;
      end else begin
        mem0[wp_r] <= mem0[wp_r];
        mem1[wp_r] <= mem1[wp_r];
      end
      rd0_r <= mem0[raddr_s][31:4];
      rd1_r <= mem1[raddr_s][31:4];
    end
  end

  // MAC pipeline: product register, accumulator and output capture
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      rd_v_r      <= 1'b0;
      prod_v_r    <= 1'b0;
      prod0_r     <= 60'sd0;
      prod1_r     <= 60'sd0;
      acc0_r      <= '0;
      acc1_r      <= '0;
      y0_r        <= 32'd0;
      y1_r        <= 32'd0;
      out_valid_r <= 1'b0;
    end else if (!enable) begin
      rd_v_r      <= 1'b0;
      prod_v_r    <= 1'b0;
      prod0_r     <= 60'sd0;
      prod1_r     <= 60'sd0;
      acc0_r      <= '0;
      acc1_r      <= '0;
      y0_r        <= 32'd0;
      y1_r        <= 32'd0;
      out_valid_r <= 1'b0;
    end else begin
      rd_v_r      <= (state_r == ST_MAC);
      prod_v_r    <= rd_v_r;
      prod0_r     <= 60'(rd0_r) * 60'($signed(coef_data));
      prod1_r     <= 60'(rd1_r) * 60'($signed(coef_data));
      out_valid_r <= (state_r == ST_DONE);
      if (state_r == ST_DONE) begin
        y0_r   <= scale_acc(acc0_r);
        y1_r   <= scale_acc(acc1_r);
        acc0_r <= '0;
        acc1_r <= '0;
      end else if (prod_v_r) begin
        y0_r   <= y0_r;
        y1_r   <= y1_r;
        acc0_r <= acc0_r + ACC_W'(prod0_r);
        acc1_r <= acc1_r + ACC_W'(prod1_r);
      end else begin
        y0_r   <= y0_r;
        y1_r   <= y1_r;
        acc0_r <= acc0_r;
        acc1_r <= acc1_r;
      end
    end
  end

  assign coef_addr     = tap_r;
  assign busy          = busy_r;
  assign overrun       = overrun_r;
  assign bus.out_valid = out_valid_r;
  assign bus.y_0       = y0_r;
  assign bus.y_1       = y1_r;

endmodule
